// File: rtl/seg_indexer_pipe.sv
// seg_indexer_pipe: pipelined FP16 binary-search segment indexer over a programmable breakpoint table.
module seg_indexer_pipe #(
    parameter int DW       = 16,
    parameter int SEG_BITS = 3
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_x,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SEG_BITS-1:0] out_seg,
    output logic [DW-1:0]       out_x,
    output logic                out_under,
    output logic                out_over,
    output logic                out_nan,
    input  logic                cfg_we,
    output logic                cfg_ready,
    input  logic [SEG_BITS-1:0] cfg_addr,
    input  logic [DW-1:0]       cfg_data
);
    localparam int NSEG = 1 << SEG_BITS;
    localparam int NS   = SEG_BITS + 1;

    function automatic logic [DW-1:0] key_of(input logic [DW-1:0] x);
        logic [DW-1:0] c;
        c = (x == 16'h8000) ? '0 : x;
        return c[DW-1] ? ~c : c ^ 16'h8000;
    endfunction

    // k/NSEG as FP16: k = 1.m * 2^p, so exponent is 15 + p - SEG_BITS
    function automatic logic [15:0] bp_default(input int k);
        int p;
        p = 0;
        for (int i = 0; i < 7; i++) if ((k >> i) != 0) p = i;
        return {1'b0, 5'(15 + p - SEG_BITS), 10'((k << (10 - p)) & 'h3FF)};
    endfunction

    logic [DW-1:0]       bp   [NSEG];
    logic [NS-1:0]       v, un_q, ov_q, na_q;
    logic [DW-1:0]       x_q  [NS];
    logic [SEG_BITS-1:0] s_q  [NS];
    logic [DW-1:0]       k_q  [SEG_BITS];
    logic [SEG_BITS-1:0] fo_q;
    logic [SEG_BITS-1:0] cand [SEG_BITS];
    logic [SEG_BITS-1:0] nxt  [SEG_BITS];
    logic                stall, nan_c, und_c, ovr_c, acc;

    assign stall     = v[NS-1] && !out_ready;
    assign cfg_ready = ~|v;
    assign in_ready  = !stall && !(cfg_we && cfg_ready);
    assign acc       = in_valid && in_ready;
    assign nan_c     = &in_x[14:10] && |in_x[9:0];
    assign und_c     = !nan_c && in_x[15] && in_x != 16'h8000;
    assign ovr_c     = !nan_c && !in_x[15] && in_x[14:0] >= 15'h3C00;

    assign out_valid = v[NS-1];
    assign out_seg   = s_q[NS-1];
    assign out_x     = x_q[NS-1];
    assign out_under = un_q[NS-1];
    assign out_over  = ov_q[NS-1];
    assign out_nan   = na_q[NS-1];

    always_comb begin
        for (int j = 1; j <= SEG_BITS; j++) begin
            cand[j-1] = s_q[j-1] | SEG_BITS'(1 << (SEG_BITS - j));
            nxt[j-1]  = (!fo_q[j-1] && k_q[j-1] > key_of(bp[cand[j-1]])) ? cand[j-1] : s_q[j-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v    <= '0;
            un_q <= '0;
            ov_q <= '0;
            na_q <= '0;
            fo_q <= '0;
            for (int i = 0; i < NS; i++) begin
                x_q[i] <= '0;
                s_q[i] <= '0;
            end
            for (int i = 0; i < SEG_BITS; i++) k_q[i] <= '0;
            bp[0] <= '0;
            for (int i = 1; i < NSEG; i++) bp[i] <= bp_default(i);
        end else begin
            if (cfg_we && cfg_ready && cfg_addr != '0) bp[cfg_addr] <= cfg_data;
            if (!stall) begin
                v[0]    <= acc;
                x_q[0]  <= in_x;
                k_q[0]  <= key_of(in_x);
                s_q[0]  <= (nan_c || ovr_c) ? '1 : '0;
                fo_q[0] <= nan_c || und_c || ovr_c;
                un_q[0] <= und_c;
                ov_q[0] <= ovr_c;
                na_q[0] <= nan_c;
                for (int j = 1; j < NS; j++) begin
                    v[j]    <= v[j-1];
                    x_q[j]  <= x_q[j-1];
                    s_q[j]  <= nxt[j-1];
                    un_q[j] <= un_q[j-1];
                    ov_q[j] <= ov_q[j-1];
                    na_q[j] <= na_q[j-1];
                end
                for (int j = 1; j < SEG_BITS; j++) begin
                    k_q[j]  <= k_q[j-1];
                    fo_q[j] <= fo_q[j-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_indexer_pipe.sv
// tb_seg_indexer_pipe: table-driven directed checks of seg_indexer_pipe with SEG_BITS=3.
module tb_seg_indexer_pipe;
    typedef struct {
        logic [15:0] x;
        logic [2:0]  seg;
        logic        u, o, n;
    } vec_t;
    typedef struct {
        vec_t v;
        int   c;
    } ent_t;

    logic        clk = 0, rstn = 0, in_valid = 0, out_ready = 1, cfg_we = 0;
    logic [15:0] in_x = 0, cfg_data = 0;
    logic [2:0]  cfg_addr = 0;
    logic        in_ready, out_valid, out_under, out_over, out_nan, cfg_ready;
    logic [2:0]  out_seg;
    logic [15:0] out_x;

    int   vecs = 0, errs = 0, cyc = 0;
    bit   lat_chk = 0, bp_mode = 0, prev_stall = 0;
    logic [22:0] prev_out;
    vec_t tbl [16];
    vec_t cur;
    ent_t q [$];

    seg_indexer_pipe #(.DW(16), .SEG_BITS(3)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_seg(out_seg), .out_x(out_x),
        .out_under(out_under), .out_over(out_over), .out_nan(out_nan),
        .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [21:0] rec(input vec_t v);
        return {v.n, v.o, v.u, v.seg, v.x};
    endfunction

    // scoreboard: capture accepted inputs, check emitted results, stall stability and in_ready
    always @(negedge clk) begin
        if (!rstn) prev_stall = 0;
        else begin
            if (in_valid && in_ready) q.push_back('{v: cur, c: cyc});
            if (!cfg_we) chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (prev_stall)
                chk("stall_hold", 32'({out_valid, out_nan, out_over, out_under, out_seg, out_x}), 32'(prev_out));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    errs++;
                    $display("FAIL spurious_out: got x=%h with no pending input", out_x);
                end else begin
                    ent_t e;
                    e = q.pop_front();
                    chk("result", 32'({out_nan, out_over, out_under, out_seg, out_x}), 32'(rec(e.v)));
                    if (lat_chk) chk("latency", 32'(cyc - e.c), 32'd4);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_valid, out_nan, out_over, out_under, out_seg, out_x};
        end
    end

    int bp_idx = 0;
    initial forever begin
        @(posedge clk); #1;
        if (bp_mode) begin
            out_ready = (bp_idx % 4 == 0) || (bp_idx % 4 == 3);
            bp_idx++;
        end
    end

    task automatic send(input vec_t v);
        bit got = 0;
        in_valid = 1;
        in_x = v.x;
        cur = v;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 0;
        if (!got) begin
            errs++;
            $display("FAIL send_timeout: x=%h never accepted", v.x);
        end
    endtask

    task automatic drain();
        bit done = 0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            done = q.size() == 0 && !out_valid;
        end
        if (!done) begin
            errs++;
            $display("FAIL drain_timeout: %0d results outstanding", q.size());
        end
        @(posedge clk); #1;
    endtask

    function automatic vec_t mk(input logic [15:0] x, input logic [2:0] s, input logic u, o, n);
        vec_t v;
        v.x = x; v.seg = s; v.u = u; v.o = o; v.n = n;
        return v;
    endfunction

    initial begin
        bit got;
        tbl[0]  = mk(16'h3000, 0, 0, 0, 0);
        tbl[1]  = mk(16'h3001, 1, 0, 0, 0);
        tbl[2]  = mk(16'h3800, 3, 0, 0, 0);
        tbl[3]  = mk(16'h3801, 4, 0, 0, 0);
        tbl[4]  = mk(16'h3BFF, 7, 0, 0, 0);
        tbl[5]  = mk(16'h8000, 0, 0, 0, 0);
        tbl[6]  = mk(16'hB800, 0, 1, 0, 0);
        tbl[7]  = mk(16'h3C00, 7, 0, 1, 0);
        tbl[8]  = mk(16'h7C00, 7, 0, 1, 0);
        tbl[9]  = mk(16'h7E00, 7, 0, 0, 1);
        tbl[10] = mk(16'hFC00, 0, 1, 0, 0);
        tbl[11] = mk(16'h0000, 0, 0, 0, 0);
        tbl[12] = mk(16'h3900, 4, 0, 0, 0);
        tbl[13] = mk(16'hFE00, 7, 0, 0, 1);
        tbl[14] = mk(16'h3500, 2, 0, 0, 0);
        tbl[15] = mk(16'h7BFF, 7, 0, 1, 0);

        repeat (2) @(posedge clk);
        #1 rstn = 1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_bus", 32'({out_nan, out_over, out_under, out_seg, out_x}), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_cfg_ready", 32'(cfg_ready), 1);
        @(posedge clk); #1;

        // back-to-back stream with fixed latency
        lat_chk = 1;
        for (int i = 0; i < 16; i++) send(tbl[i]);
        drain();
        lat_chk = 0;

        // backpressure with out_ready pattern 1,0,0,1
        bp_idx = 0;
        bp_mode = 1;
        for (int i = 0; i < 8; i++) send(tbl[i]);
        drain();
        bp_mode = 0;
        @(posedge clk); #1 out_ready = 1;

        // reprogram bp[4] while busy
        send(tbl[0]); send(tbl[1]); send(tbl[2]);
        cfg_we = 1; cfg_addr = 4; cfg_data = 16'h3A00;
        @(negedge clk);
        chk("cfg_ready_busy", 32'(cfg_ready), 0);
        got = cfg_ready;
        for (int t = 0; t < 50 && !got; t++) begin
            @(posedge clk); #1;
            @(negedge clk);
            got = cfg_ready;
        end
        chk("cfg_drained", 32'(q.size()), 0);
        chk("cfg_ready_seen", 32'(got), 1);
        @(posedge clk); #1 cfg_we = 0;
        send(mk(16'h3900, 3, 0, 0, 0));
        drain();

        // simultaneous write and input on an empty pipeline
        cfg_we = 1; cfg_addr = 2; cfg_data = 16'h3700;
        in_valid = 1; in_x = 16'h3500; cur = mk(16'h3500, 1, 0, 0, 0);
        @(negedge clk);
        chk("sim_cfg_ready", 32'(cfg_ready), 1);
        chk("sim_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1 cfg_we = 0;
        @(negedge clk);
        chk("sim_in_next", 32'(in_ready), 1);
        @(posedge clk); #1 in_valid = 0;
        drain();

        // reset with three entries in flight and a modified table
        send(tbl[0]); send(tbl[1]); send(tbl[2]);
        rstn = 0;
        @(negedge clk);
        q.delete();
        @(negedge clk);
        chk("rst_mid_valid", 32'(out_valid), 0);
        chk("rst_mid_bus", 32'({out_nan, out_over, out_under, out_seg, out_x}), 0);
        chk("rst_mid_cfg_ready", 32'(cfg_ready), 1);
        @(posedge clk); #1 rstn = 1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            chk("rst_quiet", 32'(out_valid), 0);
        end
        @(posedge clk); #1;
        send(tbl[12]);
        send(tbl[14]);
        drain();

        chk("final_queue", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/seg_indexer_pipe.md
# seg_indexer_pipe

Parametrised, pipelined FP16 segment indexer for the piecewise-linear activation unit. For each input it returns the segment index of a programmable, monotonic breakpoint table of 2^SEG_BITS segments, using a pipelined binary search. It uses a sign-correct FP16 ordering and flags out-of-range inputs. It sits between the activation fraction/range-reduction stage and the slope/intercept LUT, with valid/ready flow control on both sides.

## Interface
- DW, 16, data width; only 16 (FP16) is supported.
- SEG_BITS, 3, log2 of the segment count; legal range 1..6; NSEG = 2^SEG_BITS.
- clk  input  1  clock; all state changes on the rising edge.
- rstn  input  1  reset; synchronous, active-low.
- in_valid  input  1  input word valid.
- in_ready  output  1  input accepted when in_valid && in_ready.
- in_x  input  DW  FP16 operand.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_seg  output  SEG_BITS  segment index, 0..NSEG-1.
- out_x  output  DW  in_x passed through, aligned with out_seg.
- out_under  output  1  in_x < 0 (−0 excluded).
- out_over  output  1  in_x ≥ 1.0 (0x3C00), including +Inf.
- out_nan  output  1  in_x is NaN.
- cfg_we  input  1  breakpoint write request.
- cfg_ready  output  1  table may be written (pipeline empty).
- cfg_addr  input  SEG_BITS  breakpoint index 1..NSEG-1; a write to 0 is ignored.
- cfg_data  input  DW  FP16 breakpoint value.

## Operation
- Breakpoint table bp[1..NSEG-1]. Reset value is bp[k] = k/NSEG, exact in FP16.
  - Defaults for SEG_BITS=3: 0x3000, 0x3400, 0x3600, 0x3800, 0x3900, 0x3A00, 0x3B00.
- The table must be nondecreasing. The block does not check this; a non-monotonic table gives an undefined out_seg.
- Segment definition: out_seg is the count of k with x > bp[k]. A value equal to a breakpoint belongs to the lower segment.
- Comparison uses ordered keys: key = sign ? ~x : x ^ 0x8000, compared unsigned. −0 (0x8000) is canonicalised to +0 before keying.
- Stage 0 (input register):
  - Computes the key and flags.
  - NaN (exp = 0x1F, mant ≠ 0): nan = 1, forced seg NSEG-1, under = over = 0.
  - Negative, including −Inf: under = 1, forced seg 0.
  - ≥ 0x3C00, including +Inf: over = 1, forced seg NSEG-1.
- Stages 1..SEG_BITS: binary search, one bit per stage, MSB first.
  - Stage j tests bit b = SEG_BITS−j.
  - cand = seg | (1<<b); if key(x) > key(bp[cand]), then seg = cand.
  - Forced results from stage 0 bypass the search.
- Flow control:
  - stall = out_valid && !out_ready. On stall, every stage holds its contents.
  - in_ready = !stall && !(cfg_we && cfg_ready).
  - Bubbles propagate, with no compaction.
- Configuration:
  - cfg_ready = 1 iff no stage holds a valid entry.
  - A write takes effect when cfg_we && cfg_ready; the new value is visible to the next accepted input.
  - cfg_we while cfg_ready = 0 is held off: no write happens, and the requester must hold cfg_we.
  - When cfg_we && cfg_ready, the write wins and in_ready is 0 that cycle.

## Timing
- Latency: input accepted at edge k gives out_valid = 1 after edge k+SEG_BITS (SEG_BITS+1 register stages), provided no stall occurs.
- Throughput: 1 result per cycle while out_ready = 1.
- A result is held stable on out_* while out_valid && !out_ready.
- in_ready is combinational from out_valid, out_ready, cfg_we and pipeline occupancy. There is no combinational path from in_x to any output.
- Reset (rstn = 0 at a rising edge):
  - All stage valids clear.
  - out_valid, out_seg, out_x, out_under, out_over and out_nan become 0.
  - The table returns to its defaults.
  - Results in flight are discarded.
- After reset: in_ready = 1 and cfg_ready = 1.
- A reset asserted mid-stall or mid-write overrides everything.

## Test plan
- SEG_BITS=3, default table; stream 0x3000, 0x3001, 0x3800, 0x3801, 0x3BFF, one per cycle, with out_ready = 1. Required: out_seg = 0, 1, 3, 4, 7, each 4 cycles after acceptance, back-to-back.
- Special values 0x8000 (−0), 0xB800 (−0.5), 0x3C00, 0x7C00, 0x7E00, 0xFC00. Required:
  - −0: seg 0, no flags.
  - −0.5: seg 0, under.
  - 1.0: seg 7, over.
  - +Inf: seg 7, over.
  - NaN: seg 7, nan.
  - −Inf: seg 0, under.
- Backpressure: stream 8 values while out_ready toggles 1,0,0,1,…. Required: no loss or duplication, order preserved, out_* stable during stall, in_ready = 0 exactly when stalled.
- Reprogramming: write bp[4] = 0x3A00 while the pipeline is busy. Required: cfg_ready = 0 until drained, then the write lands; afterwards 0x3900 gives seg 3 (was 4).
- Simultaneous cfg_we and in_valid on an empty pipeline. Required: the write is accepted, in_ready = 0 that cycle, and the input is accepted the next cycle and sees the new table.
- Assert rstn = 0 with 3 entries in flight and a modified table. Required: out_valid = 0 the next cycle, nothing emitted, table restored (0x3900 gives seg 4).
